// File: rtl/fifo_access_arbiter.sv
// Front end for a linear FIFO: round-robin arbitration of two writers plus
// a length-bounded, abortable read-burst sequencer on the read side.
module fifo_access_arbiter #(
   parameter int DATA_W = 4,
   parameter int DEPTH  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req0,
   input  logic [DATA_W-1:0]        data0,
   output logic                     gnt0,
   input  logic                     req1,
   input  logic [DATA_W-1:0]        data1,
   output logic                     gnt1,
   input  logic                     drain_start,
   input  logic [$clog2(DEPTH):0]   drain_len,
   input  logic                     drain_abort,
   output logic                     drain_busy,
   output logic                     drain_done,
   output logic                     rd_valid,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     write_enb,
   output logic [DATA_W-1:0]        datain,
   output logic                     read_enb,
   input  logic [DATA_W-1:0]        dataout,
   input  logic                     full,
   input  logic                     empty
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic             prio_q, prio_d;
   logic             rd_valid_q, rd_valid_d;
   logic             drain_done_q, drain_done_d;
   logic             gnt0_c, gnt1_c;
   logic             read_c;
   logic [CNT_W-1:0] len_clamped;

   // Write arbiter; prio_q = 0 favours requester 0 on a tie. Grants are
   // gated by rst because the priority flop alone cannot silence them.
   always_comb begin
      gnt0_c = 1'b0;
      gnt1_c = 1'b0;
      if (!rst && !full) begin
         if (req0 && (!req1 || !prio_q)) begin
            gnt0_c = 1'b1;
         end else if (req1) begin
            gnt1_c = 1'b1;
         end
      end
   end

   always_comb begin
      prio_d = prio_q;
      if (gnt0_c) begin
         prio_d = 1'b1;
      end else if (gnt1_c) begin
         prio_d = 1'b0;
      end
   end

   always_comb begin
      datain = '0;
      if (gnt0_c) begin
         datain = data0;
      end else if (gnt1_c) begin
         datain = data1;
      end
   end

   assign len_clamped = (drain_len > DEPTH_CNT) ? DEPTH_CNT : drain_len;

   // Read sequencer: an abort wins over a read in the same cycle, and an
   // empty FIFO only stalls the burst.
   always_comb begin
      state_d      = state_q;
      remaining_d  = remaining_q;
      read_c       = 1'b0;
      drain_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (drain_start && (drain_len != '0)) begin
               state_d     = BURST;
               remaining_d = len_clamped;
            end
         end
         BURST: begin
            if (drain_abort) begin
               state_d     = IDLE;
               remaining_d = '0;
            end else if ((remaining_q != '0) && !empty) begin
               read_c      = 1'b1;
               remaining_d = remaining_q - 1'b1;
               if (remaining_q == CNT_W'(1)) begin
                  state_d      = IDLE;
                  drain_done_d = 1'b1;
               end
            end
         end
         default: begin
            state_d     = IDLE;
            remaining_d = '0;
         end
      endcase
   end

   // Word data arrives one edge after read_enb, so valid/done are delayed to match.
   assign rd_valid_d = read_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         remaining_q  <= '0;
         prio_q       <= 1'b0;
         rd_valid_q   <= 1'b0;
         drain_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         remaining_q  <= remaining_d;
         prio_q       <= prio_d;
         rd_valid_q   <= rd_valid_d;
         drain_done_q <= drain_done_d;
      end
   end

   assign gnt0       = gnt0_c;
   assign gnt1       = gnt1_c;
   assign write_enb  = gnt0_c | gnt1_c;
   assign read_enb   = read_c;
   assign drain_busy = (state_q == BURST);
   assign drain_done = drain_done_q;
   assign rd_valid   = rd_valid_q;
   assign rd_data    = dataout;

endmodule

// File: tb/tb_fifo_access_arbiter.sv
// Directed bench for fifo_access_arbiter with a small behavioural linear FIFO
// attached to its FIFO-side ports.
module tb_fifo_access_arbiter;

   localparam int DW = 8;
   localparam int DP = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0, req1;
   logic [DW-1:0] data0, data1;
   logic          gnt0, gnt1;
   logic          drain_start;
   logic [4:0]    drain_len;
   logic          drain_abort;
   logic          drain_busy, drain_done, rd_valid;
   logic [DW-1:0] rd_data;
   logic          write_enb;
   logic [DW-1:0] datain;
   logic          read_enb;
   logic [DW-1:0] dataout;
   logic          full, empty;

   int checks = 0;
   int errors = 0;

   fifo_access_arbiter #(.DATA_W(DW), .DEPTH(DP)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .data0(data0), .gnt0(gnt0),
      .req1(req1), .data1(data1), .gnt1(gnt1),
      .drain_start(drain_start), .drain_len(drain_len), .drain_abort(drain_abort),
      .drain_busy(drain_busy), .drain_done(drain_done),
      .rd_valid(rd_valid), .rd_data(rd_data),
      .write_enb(write_enb), .datain(datain), .read_enb(read_enb),
      .dataout(dataout), .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   // Behavioural FIFO: dataout updates on the edge that samples read_enb.
   logic [DW-1:0] mem [DP];
   int            cnt = 0, wp = 0, rp = 0;
   logic          fifo_clr;

   always @(posedge clk) begin
      if (fifo_clr) begin
         cnt     <= 0;
         wp      <= 0;
         rp      <= 0;
         dataout <= '0;
      end else begin
         if (write_enb && !full) begin
            mem[wp] <= datain;
            wp      <= (wp + 1) % DP;
         end
         if (read_enb && !empty) begin
            dataout <= mem[rp];
            rp      <= (rp + 1) % DP;
         end
         cnt <= cnt + ((write_enb && !full) ? 1 : 0) - ((read_enb && !empty) ? 1 : 0);
      end
   end

   assign full  = (cnt == DP);
   assign empty = (cnt == 0);

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_fifo;
      fifo_clr = 1'b1;
      tick();
      fifo_clr = 1'b0;
   endtask

   task automatic preload(input logic which, input int n, input logic [DW-1:0] base);
      for (int k = 0; k < n; k++) begin
         if (which) begin req1 = 1'b1; data1 = base + DW'(k); end
         else       begin req0 = 1'b1; data0 = base + DW'(k); end
         tick();
      end
      req0 = 1'b0;
      req1 = 1'b0;
   endtask

   initial begin
      int vcount;
      rst = 1'b1; fifo_clr = 1'b1;
      req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
      drain_start = 1'b0; drain_len = '0; drain_abort = 1'b0;
      tick();
      tick();

      // Reset: outputs silent even with both requests high
      req0 = 1'b1; req1 = 1'b1; data0 = 8'h03; data1 = 8'h0C;
      #1;
      check_eq("rst_gnt0", gnt0, 0);
      check_eq("rst_gnt1", gnt1, 0);
      check_eq("rst_wen", write_enb, 0);
      check_eq("rst_datain", datain, 0);
      check_eq("rst_ren", read_enb, 0);
      check_eq("rst_rdv", rd_valid, 0);
      check_eq("rst_busy", drain_busy, 0);
      check_eq("rst_done", drain_done, 0);
      $display("reset checks done");

      // Alternating grants until full
      rst = 1'b0; fifo_clr = 1'b0;
      for (int i = 0; i < 16; i++) begin
         #1;
         check_eq("alt_gnt0", gnt0, (i % 2 == 0) ? 1 : 0);
         check_eq("alt_gnt1", gnt1, (i % 2 == 0) ? 0 : 1);
         check_eq("alt_datain", datain, (i % 2 == 0) ? 32'h03 : 32'h0C);
         tick();
      end
      #1;
      check_eq("full_gnt0", gnt0, 0);
      check_eq("full_gnt1", gnt1, 0);
      check_eq("full_wen", write_enb, 0);
      $display("alternating writes: 16 granted, then blocked on full");
      req0 = 1'b0; req1 = 1'b0;
      clear_fifo();

      // req1 alone three times, then requester 0 wins the tie
      req1 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check_eq("solo_gnt1", gnt1, 1);
         check_eq("solo_gnt0", gnt0, 0);
         tick();
      end
      req0 = 1'b1;
      #1;
      check_eq("tie_gnt0", gnt0, 1);
      check_eq("tie_gnt1", gnt1, 0);
      tick();
      req0 = 1'b0; req1 = 1'b0;
      $display("solo req1 then tie: gnt0 first");
      clear_fifo();

      // Full 16-word drain
      preload(1'b0, 16, 8'd1);
      drain_start = 1'b1; drain_len = 5'd16;
      #1;
      check_eq("d16_ren_idle", read_enb, 0);
      tick();
      drain_start = 1'b0;
      for (int k = 0; k < 16; k++) begin
         #1;
         check_eq("d16_ren", read_enb, 1);
         check_eq("d16_busy", drain_busy, 1);
         check_eq("d16_rdv", rd_valid, (k > 0) ? 1 : 0);
         if (k > 0) check_eq("d16_data", rd_data, k);
         check_eq("d16_done_early", drain_done, 0);
         tick();
      end
      #1;
      check_eq("d16_last_rdv", rd_valid, 1);
      check_eq("d16_last_data", rd_data, 16);
      check_eq("d16_done", drain_done, 1);
      check_eq("d16_busy_end", drain_busy, 0);
      check_eq("d16_ren_end", read_enb, 0);
      tick();
      check_eq("d16_done_pulse", drain_done, 0);
      check_eq("d16_rdv_end", rd_valid, 0);
      check_eq("d16_empty", empty, 1);
      $display("burst of 16: words 1..16 read, done on last");

      // Stall on empty, resume after writes
      clear_fifo();
      preload(1'b1, 2, 8'h10);
      drain_start = 1'b1; drain_len = 5'd4;
      tick();
      drain_start = 1'b0;
      #1; check_eq("st_ren0", read_enb, 1);
      tick();
      check_eq("st_ren1", read_enb, 1);
      check_eq("st_data1", rd_data, 32'h10);
      tick();
      check_eq("st_ren_stall", read_enb, 0);
      check_eq("st_data2", rd_data, 32'h11);
      check_eq("st_busy", drain_busy, 1);
      tick();
      check_eq("st_rdv_stall", rd_valid, 0);
      check_eq("st_busy2", drain_busy, 1);
      req0 = 1'b1; data0 = 8'h12;
      #1;
      check_eq("st_wgnt", gnt0, 1);
      check_eq("st_ren_still", read_enb, 0);
      tick();
      data0 = 8'h13;
      #1;
      check_eq("st_ren_resume", read_enb, 1);
      check_eq("st_wgnt2", gnt0, 1);
      tick();
      req0 = 1'b0;
      #1;
      check_eq("st_ren4", read_enb, 1);
      check_eq("st_data3", rd_data, 32'h12);
      check_eq("st_done_early", drain_done, 0);
      tick();
      check_eq("st_data4", rd_data, 32'h13);
      check_eq("st_done", drain_done, 1);
      check_eq("st_busy_end", drain_busy, 0);
      tick();
      $display("stalled burst of 4 resumed and completed");

      // Abort after 3 of 8 reads
      clear_fifo();
      preload(1'b0, 8, 8'h20);
      drain_start = 1'b1; drain_len = 5'd8;
      tick();
      drain_start = 1'b0;
      vcount = 0;
      for (int k = 0; k < 3; k++) begin
         #1;
         check_eq("ab_ren", read_enb, 1);
         tick();
         if (rd_valid) vcount++;
      end
      check_eq("ab_data3", rd_data, 32'h22);
      drain_abort = 1'b1;
      #1;
      check_eq("ab_ren_blocked", read_enb, 0);
      check_eq("ab_busy", drain_busy, 1);
      tick();
      drain_abort = 1'b0;
      if (rd_valid) vcount++;
      check_eq("ab_busy_fall", drain_busy, 0);
      check_eq("ab_done", drain_done, 0);
      tick();
      if (rd_valid) vcount++;
      check_eq("ab_done2", drain_done, 0);
      check_eq("ab_valid_count", vcount, 3);
      check_eq("ab_left", cnt, 5);
      $display("aborted burst: %0d words read", vcount);

      // Zero length is ignored
      drain_start = 1'b1; drain_len = 5'd0;
      tick();
      drain_start = 1'b0;
      #1;
      check_eq("z_busy", drain_busy, 0);
      check_eq("z_ren", read_enb, 0);

      // Over-long length clamps to DEPTH; restart inside a burst is ignored
      clear_fifo();
      preload(1'b1, 16, 8'h40);
      drain_start = 1'b1; drain_len = 5'd31;
      tick();
      for (int k = 0; k < 16; k++) begin
         drain_start = (k == 5);
         drain_len   = (k == 5) ? 5'd2 : 5'd31;
         #1;
         check_eq("cl_ren", read_enb, 1);
         tick();
      end
      drain_start = 1'b0;
      check_eq("cl_done", drain_done, 1);
      check_eq("cl_busy", drain_busy, 0);
      check_eq("cl_data", rd_data, 32'h4F);
      tick();
      check_eq("cl_empty", empty, 1);
      $display("clamped burst: 16 words, restart ignored");

      // Reset mid-burst with concurrent writes
      preload(1'b0, 4, 8'h50);
      drain_start = 1'b1; drain_len = 5'd4;
      tick();
      drain_start = 1'b0;
      #1; check_eq("rb_ren", read_enb, 1);
      tick();
      req0 = 1'b1; data0 = 8'h60;
      #1; check_eq("rb_gnt0", gnt0, 1);
      tick();
      req1 = 1'b1; data1 = 8'h61;
      rst = 1'b1;
      #1;
      check_eq("rb_gnt0_rst", gnt0, 0);
      check_eq("rb_gnt1_rst", gnt1, 0);
      check_eq("rb_wen_rst", write_enb, 0);
      check_eq("rb_datain_rst", datain, 0);
      check_eq("rb_ren_rst", read_enb, 0);
      check_eq("rb_rdv_rst", rd_valid, 0);
      check_eq("rb_busy_rst", drain_busy, 0);
      check_eq("rb_done_rst", drain_done, 0);
      tick();
      rst = 1'b0;
      #1;
      check_eq("rb_prio_gnt0", gnt0, 1);
      check_eq("rb_prio_gnt1", gnt1, 0);
      check_eq("rb_busy_after", drain_busy, 0);
      req0 = 1'b0; req1 = 1'b0;
      tick();
      check_eq("rb_done_after", drain_done, 0);
      check_eq("rb_rdv_after", rd_valid, 0);
      $display("reset during burst: block idle, priority back to requester 0");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_access_arbiter.md
FIFO_ACCESS_ARBITER -- requirements
Module: fifo_access_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 4, width of each write-data port and the FIFO data path.
REQ-002 The block SHALL have parameter DEPTH, default 16, number of entries in the attached linear_fifo.
REQ-003 The block SHALL have a single clock and an asynchronous active-high reset.
REQ-004 Ports SHALL be, in order:
- clk  input  1  clock; all state rising-edge.
- rst  input  1  asynchronous active-high reset.
- req0  input  1  requester 0 write request, level.
- data0  input  DATA_W  requester 0 write data.
- gnt0  output  1  requester 0 granted this cycle.
- req1  input  1  requester 1 write request, level.
- data1  input  DATA_W  requester 1 write data.
- gnt1  output  1  requester 1 granted this cycle.
- drain_start  input  1  one-cycle pulse starting a read burst.
- drain_len  input  $clog2(DEPTH)+1  burst length, sampled with drain_start.
- drain_abort  input  1  terminate the active burst.
- drain_busy  output  1  burst in progress.
- drain_done  output  1  one-cycle pulse on the last word of a burst.
- rd_valid  output  1  rd_data holds a word read from the FIFO.
- rd_data  output  DATA_W  FIFO dataout, passed through.
- write_enb  output  1  to FIFO write_enb.
- datain  output  DATA_W  to FIFO datain.
- read_enb  output  1  to FIFO read_enb.
- dataout  input  DATA_W  from FIFO dataout.
- full  input  1  from FIFO full.
- empty  input  1  from FIFO empty.

Function
REQ-005 The write grant SHALL be combinational from req0, req1, full and the priority register: at most one gnt asserted; no gnt while full=1.
REQ-006 When only one req is high and full=0, that requester SHALL be granted.
REQ-007 When both reqs are high and full=0, the requester named by the 1-bit priority register SHALL be granted.
REQ-008 After any grant, the priority register SHALL point to the other requester on the next edge; it SHALL be unchanged in cycles with no grant.
REQ-009 write_enb SHALL equal gnt0|gnt1; datain SHALL equal data0 when gnt0, data1 when gnt1, and 0 otherwise.
REQ-010 The read sequencer SHALL be an FSM with states IDLE and BURST, and a remaining-count register of width $clog2(DEPTH)+1.
REQ-011 IDLE->BURST SHALL occur on drain_start=1 with drain_len!=0, loading remaining=drain_len; drain_start with drain_len=0 SHALL be ignored.
REQ-012 drain_len values greater than DEPTH SHALL be clamped to DEPTH.
REQ-013 drain_start while in BURST SHALL be ignored.
REQ-014 In BURST, read_enb SHALL be asserted combinationally whenever remaining!=0 and empty=0; each asserted cycle SHALL decrement remaining by 1.
REQ-015 A BURST with empty=1 SHALL stall with read_enb=0 and remaining held; it SHALL NOT abort.
REQ-016 BURST->IDLE SHALL occur on the edge where the final read is issued (remaining 1->0), or on drain_abort=1.
REQ-017 drain_abort SHALL take priority over a read in the same cycle: read_enb=0 that cycle.
REQ-018 drain_busy SHALL be 1 exactly while the state is BURST.
REQ-019 rd_valid SHALL be read_enb registered by one cycle; rd_data SHALL equal dataout. The FIFO presents dataout on the edge after read_enb is sampled.
REQ-020 drain_done SHALL pulse for one cycle, coincident with the rd_valid of the burst's final word; an aborted burst SHALL produce no drain_done.
REQ-021 Write grants and burst reads SHALL operate independently and concurrently. While full=1, writes SHALL remain blocked even if a read occurs in the same cycle.

Reset
REQ-022 While rst=1, the following SHALL be 0: gnt0, gnt1, write_enb, datain, read_enb, rd_valid, drain_busy, drain_done.
REQ-023 Reset SHALL force state=IDLE, remaining=0 and priority=requester 0.
REQ-024 Reset asserted mid-burst SHALL return the block to IDLE immediately, with no drain_done.

Verification
REQ-025 Scenario: after reset, hold req0=req1=1 with data0=4'h3, data1=4'hC -> grants alternate gnt0,gnt1,gnt0..., datain alternates 3,C; 16 writes complete, then full=1 and no further grant.
REQ-026 Scenario: only req1=1 for 3 cycles, then both high -> gnt1 three times, then gnt0 first.
REQ-027 Scenario: FIFO holds 16 words 1..16; drain_start with drain_len=16 -> read_enb high 16 consecutive cycles; rd_valid high 16 cycles, one cycle later, rd_data 1..16; drain_done coincides with word 16; empty=1 afterwards.
REQ-028 Scenario: FIFO holds 2 words; drain_len=4 -> 2 reads, stall while empty; 2 further writes resume the burst; drain_done fires after the 4th word.
REQ-029 Scenario: drain_abort after 3 reads of an 8-word burst -> drain_busy falls the next cycle, 3 rd_valid, no drain_done, 5 words remain.
REQ-030 Scenario: rst pulse during BURST and concurrent writes -> all outputs 0 immediately; priority = requester 0 after release.
